// File: rtl/izh_neuron_array.sv
// izh_neuron_array: NUM_NEURONS Izhikevich channels time-multiplexed onto one update datapath.
// Ports:
//   clk, reset (sync, active-low), enable, input_enable : clocking / run control
//   stimulus_in  : per-channel unsigned stimulus, channel i at [i*STIM_W +: STIM_W]
//   load_mode, serial_data : framed MSB-first parameter loader {ch, a, b, c, d}
//   mon_sel / membrane_out : registered top byte of v for the selected channel
//   spike_out, params_ready : per-channel flags
//   load_done, load_err, sweep_done : one-cycle status pulses
// Optional feature: define IZH_REFRACTORY_EN for per-channel refractory counters.
module izh_neuron_array #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned CH_W = 2,
    parameter int unsigned PARAM_W = 6,
    parameter int unsigned STATE_W = 16,
    parameter int unsigned STIM_W = 8,
    parameter int unsigned SQ_SHIFT = 8,
    parameter int unsigned DT_SHIFT = 2,
    parameter logic signed [STATE_W-1:0] V_PEAK = 16'sd120,
    parameter int unsigned REFRAC_CYCLES = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          input_enable,
    input  logic [NUM_NEURONS*STIM_W-1:0] stimulus_in,
    input  logic                          load_mode,
    input  logic                          serial_data,
    input  logic [CH_W-1:0]               mon_sel,
    output logic [7:0]                    membrane_out,
    output logic [NUM_NEURONS-1:0]        spike_out,
    output logic [NUM_NEURONS-1:0]        params_ready,
    output logic                          load_done,
    output logic                          load_err,
    output logic                          sweep_done
);
    localparam int unsigned FRAME_W = CH_W + 4 * PARAM_W;
    localparam int unsigned CNT_W = $clog2(FRAME_W + 1);
    localparam int unsigned MATH_W = 2 * STATE_W + 4;
    localparam logic signed [MATH_W-1:0] K_FIVE = MATH_W'(5);
    localparam logic signed [MATH_W-1:0] K_140 = MATH_W'(140);
    localparam logic signed [MATH_W-1:0] S_MAX = {{(MATH_W-STATE_W+1){1'b0}}, {(STATE_W-1){1'b1}}};
    localparam logic signed [MATH_W-1:0] S_MIN = {{(MATH_W-STATE_W+1){1'b1}}, {(STATE_W-1){1'b0}}};

    function automatic logic signed [MATH_W-1:0] sext_state(input logic signed [STATE_W-1:0] x);
        return {{(MATH_W-STATE_W){x[STATE_W-1]}}, x};
    endfunction

    function automatic logic signed [MATH_W-1:0] sext_param(input logic signed [PARAM_W-1:0] x);
        return {{(MATH_W-PARAM_W){x[PARAM_W-1]}}, x};
    endfunction

    function automatic logic signed [STATE_W-1:0] param_to_state(input logic signed [PARAM_W-1:0] x);
        return {{(STATE_W-PARAM_W){x[PARAM_W-1]}}, x};
    endfunction

    function automatic logic signed [STATE_W-1:0] sat(input logic signed [MATH_W-1:0] x);
        if (x > S_MAX) return S_MAX[STATE_W-1:0];
        if (x < S_MIN) return S_MIN[STATE_W-1:0];
        return x[STATE_W-1:0];
    endfunction

    logic signed [STATE_W-1:0] v_q [NUM_NEURONS];
    logic signed [STATE_W-1:0] u_q [NUM_NEURONS];
    logic signed [PARAM_W-1:0] a_q [NUM_NEURONS];
    logic signed [PARAM_W-1:0] b_q [NUM_NEURONS];
    logic signed [PARAM_W-1:0] c_q [NUM_NEURONS];
    logic signed [PARAM_W-1:0] d_q [NUM_NEURONS];
    logic [CH_W-1:0]           ptr_q;

    // Loader: the shift register holds all but the newest bit; frame is the full candidate word.
    logic [FRAME_W-2:0]        shift_q;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [FRAME_W-1:0]        frame;
    logic [CH_W-1:0]           frame_ch;
    logic signed [PARAM_W-1:0] frame_a, frame_b, frame_c, frame_d;
    logic                      commit, err;

    assign frame    = {shift_q, serial_data};
    assign frame_ch = frame[FRAME_W-1 -: CH_W];
    assign frame_a  = frame[4*PARAM_W-1 -: PARAM_W];
    assign frame_b  = frame[3*PARAM_W-1 -: PARAM_W];
    assign frame_c  = frame[2*PARAM_W-1 -: PARAM_W];
    assign frame_d  = frame[PARAM_W-1:0];

    always_comb begin
        cnt_d  = '0;
        commit = 1'b0;
        err    = 1'b0;
        if (load_mode) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                cnt_d = '0;
                if (int'(frame_ch) < NUM_NEURONS) commit = 1'b1;
                else                              err    = 1'b1;
            end
        end
    end

    // Update datapath for the channel under the pointer.
    logic                      upd_en, visit, fire, refr_active;
    logic signed [STATE_W-1:0] v_cur, v_upd, u_upd, v_mon;
    logic signed [MATH_W-1:0]  v_x, u_x, a_x, b_x, d_x, stim_x, vv, dv, bv;

`ifdef IZH_REFRACTORY_EN
    localparam int unsigned REF_W = $clog2(REFRAC_CYCLES + 1);
    logic [REF_W-1:0] ref_q [NUM_NEURONS];
    logic [REF_W-1:0] ref_upd;
`endif

    assign upd_en = enable & input_enable;
    assign visit  = upd_en & params_ready[ptr_q];

    always_comb begin
        v_cur  = v_q[ptr_q];
        v_x    = sext_state(v_cur);
        u_x    = sext_state(u_q[ptr_q]);
        a_x    = sext_param(a_q[ptr_q]);
        b_x    = sext_param(b_q[ptr_q]);
        d_x    = sext_param(d_q[ptr_q]);
        stim_x = {{(MATH_W-STIM_W){1'b0}}, stimulus_in[ptr_q*STIM_W +: STIM_W]};
`ifdef IZH_REFRACTORY_EN
        refr_active = (ref_q[ptr_q] != '0);
`else
        refr_active = 1'b0;
`endif
        if (refr_active) stim_x = '0;
        fire = !refr_active && (v_cur >= V_PEAK);
        vv   = (v_x * v_x) >>> SQ_SHIFT;
        dv   = vv + K_FIVE * v_x + K_140 - u_x + stim_x;
        bv   = (b_x * v_x) >>> 4;
        if (fire) begin
            v_upd = param_to_state(c_q[ptr_q]);
            u_upd = sat(u_x + d_x);
        end else begin
            v_upd = sat(v_x + (dv >>> DT_SHIFT));
            u_upd = sat(u_x + ((a_x * (bv - u_x)) >>> 8));
        end
`ifdef IZH_REFRACTORY_EN
        if (fire)             ref_upd = REF_W'(REFRAC_CYCLES);
        else if (refr_active) ref_upd = ref_q[ptr_q] - REF_W'(1);
        else                  ref_upd = '0;
`endif
    end

    // Monitor sees the post-edge value of v, including a same-edge commit.
    always_comb begin
        if (commit && frame_ch == mon_sel)    v_mon = param_to_state(frame_c);
        else if (visit && ptr_q == mon_sel)   v_mon = v_upd;
        else                                  v_mon = v_q[mon_sel];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                v_q[i] <= '0;
                u_q[i] <= '0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
                d_q[i] <= '0;
`ifdef IZH_REFRACTORY_EN
                ref_q[i] <= '0;
`endif
            end
            ptr_q        <= '0;
            shift_q      <= '0;
            cnt_q        <= '0;
            membrane_out <= '0;
            spike_out    <= '0;
            params_ready <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            sweep_done   <= 1'b0;
        end else begin
            if (load_mode) shift_q <= frame[FRAME_W-2:0];
            cnt_q      <= cnt_d;
            load_done  <= commit;
            load_err   <= err;
            sweep_done <= upd_en && (ptr_q == CH_W'(NUM_NEURONS - 1));
            if (upd_en) begin
                ptr_q <= (ptr_q == CH_W'(NUM_NEURONS - 1)) ? '0 : ptr_q + CH_W'(1);
                if (params_ready[ptr_q]) begin
                    v_q[ptr_q]       <= v_upd;
                    u_q[ptr_q]       <= u_upd;
                    spike_out[ptr_q] <= fire;
`ifdef IZH_REFRACTORY_EN
                    ref_q[ptr_q]     <= ref_upd;
`endif
                end else begin
                    spike_out[ptr_q] <= 1'b0;
                end
            end
            // Later assignment wins: a commit overrides a same-edge update of that channel.
            if (commit) begin
                a_q[frame_ch]          <= frame_a;
                b_q[frame_ch]          <= frame_b;
                c_q[frame_ch]          <= frame_c;
                d_q[frame_ch]          <= frame_d;
                v_q[frame_ch]          <= param_to_state(frame_c);
                u_q[frame_ch]          <= '0;
                spike_out[frame_ch]    <= 1'b0;
                params_ready[frame_ch] <= 1'b1;
`ifdef IZH_REFRACTORY_EN
                ref_q[frame_ch]        <= '0;
`endif
            end
            membrane_out <= v_mon[STATE_W-1 -: 8];
        end
    end

endmodule

// File: doc/izh_neuron_array.md
Name: izh_neuron_array

Overview:
- Parametrised successor to the single-neuron Izhikevich system: NUM_NEURONS independent Izhikevich channels share one time-multiplexed update datapath.
- Per-channel state (v, u) and parameters (a, b, c, d) live in register arrays. A framed serial loader writes the parameters of one addressed channel per frame.
- Sits between the stimulus/pin interface and downstream spike consumers. Exports a spike vector plus a selectable membrane monitor.

Parameters:
- NUM_NEURONS, 4: channel count, 2..16.
- CH_W, 2: channel index width, equal to clog2(NUM_NEURONS).
- PARAM_W, 6: width of each of a, b, c, d; all signed two's complement.
- STATE_W, 16: signed width of v and u.
- STIM_W, 8: unsigned per-channel stimulus width.
- SQ_SHIFT, 8: right shift applied to v*v.
- DT_SHIFT, 2: right shift applied to dv (integration step).
- V_PEAK, 16'sd120: spike threshold on v.
- REFRAC_CYCLES, 3: refractory visits, used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global run enable.
- input_enable  in  1  gates neuron updates; ANDed with enable.
- stimulus_in  in  NUM_NEURONS*STIM_W  channel i occupies bits [i*STIM_W +: STIM_W].
- load_mode  in  1  frame-active strobe for the serial loader.
- serial_data  in  1  loader bit, sampled MSB-first.
- mon_sel  in  CH_W  channel routed to membrane_out.
- membrane_out  out  8  v[STATE_W-1 -: 8] of channel mon_sel (registered).
- spike_out  out  NUM_NEURONS  per-channel spike flag.
- params_ready  out  NUM_NEURONS  channel has valid parameters.
- load_done  out  1  one-cycle pulse on frame commit.
- load_err  out  1  one-cycle pulse on a bad channel index.
- sweep_done  out  1  one-cycle pulse when the update pointer wraps.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All v, u, params, ptr, bit counter and shift register go to 0.
  - All outputs go to 0.
  - Reset has priority over everything, including an in-flight frame, which is lost.
- Loader:
  - Frame length F = CH_W + 4*PARAM_W bits, laid out {ch, a, b, c, d}, MSB first.
  - Each cycle with load_mode==1: shift in serial_data and increment the bit counter. The loader runs regardless of enable.
  - When the counter reaches F, on the cycle the last bit is shifted in:
    - ch < NUM_NEURONS: commit the params, set params_ready[ch], set v[ch] = sext(c), u[ch] = 0, clear spike_out[ch], and pulse load_done on the following cycle.
    - ch >= NUM_NEURONS: discard the frame and pulse load_err.
    - In both cases the counter returns to 0.
  - load_mode dropping before F bits: the partial frame is discarded and the counter clears. No pulse.
  - Back-to-back frames are legal with no gap cycle.
- Update engine:
  - When enable & input_enable, ptr advances by 1 each cycle and wraps from NUM_NEURONS-1 to 0. sweep_done pulses on the cycle after the wrap edge.
  - When not enabled, ptr and all state hold.
  - Channel p = ptr is updated at the clock edge only if params_ready[p]. Otherwise its state holds and spike_out[p] = 0.
  - Spike case, v >= V_PEAK:
    - v <= sext(c).
    - u <= sat(u + sext(d)).
    - spike_out[p] <= 1.
  - Non-spike case:
    - dv = ((v*v) >>> SQ_SHIFT) + 5*v + 140 - u + I, with I = zero-extended stim[p].
    - v <= sat(v + (dv >>> DT_SHIFT)).
    - u <= sat(u + ((a * (((b*v) >>> 4) - u)) >>> 8)).
    - spike_out[p] <= 0.
  - All intermediate math is done at 2*STATE_W+4 signed width. sat() clamps to the STATE_W signed range.
  - spike_out[p] holds its value until channel p is next visited, so a spike is visible for NUM_NEURONS cycles.
- Commit collision: a loader commit to channel p on the same edge that updates p wins entirely. The state update is dropped.
- membrane_out: registered from v[mon_sel] after that edge's update, giving one cycle of latency.

Optional Feature:
- Macro: IZH_REFRACTORY_EN.
- Defined:
  - Each channel gets a counter that loads REFRAC_CYCLES on a spike and decrements on each visit of that channel.
  - While the counter is nonzero, I is forced to 0 and the spike test is suppressed.
  - A loader commit clears the counter.
- Undefined: no counters exist and behaviour is exactly as above.

Test Plan:
1. Reset low 2 cycles, then high → all outputs 0, params_ready = 4'b0000. Enabled sweep → spike_out stays 0 and state holds because no params are loaded.
2. Load a frame with ch=2, a=2, b=13, c=-8, d=8 → load_done pulses once and params_ready = 4'b0100. Channel 2 resets to v = -8, u = 0; channels 0, 1 and 3 are unchanged.
3. Channel 2 loaded, stim[2] = 255, enable=1 → v[2] rises monotonically and spike_out[2] goes high within 200 sweeps. v[2] then returns to -8 and u[2] increases by 8. sweep_done pulses every 4 cycles.
4. Frame with ch=3 on NUM_NEURONS=3 → load_err pulses and params_ready is unchanged. Separately, a frame aborted after 10 bits is followed by a full valid frame → only the valid frame commits.
5. Commit to channel 1 on the same edge ptr==1 → v[1] = sext(c), u[1] = 0, spike_out[1] = 0. Reset asserted mid-frame → the next full frame loads correctly from bit 0.
6. With IZH_REFRACTORY_EN defined and REFRAC_CYCLES=3 → after a spike, the channel produces no spike for the next 3 visits even with v >= V_PEAK and stim = 255.
